uart_baud_gen_nco: RTL and testbench

Parametrised successor to the fixed-divider BaudGenT/BaudGenR pair. A single fractional phase accumulator (NCO) generates the oversample tick. TX bit ticks and RX mid-bit sample ticks are derived from it, replacing the separate TX and RX generators. Rate comes from a runtime-selectable table or a custom increment, and RX phase can be re-aligned on each start-bit edge.

---
 rtl/uart_baud_pkg.sv | 25 ++
 rtl/uart_baud_nco.sv | 36 +++
 rtl/uart_baud_gen_nco.sv | 114 +++++++++++
 tb/tb_uart_baud_gen_nco.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg: shared constants for the NCO baud generator.
//   RATE_BAUD  - default baud table selected by baud_sel
//   calc_inc   - elaboration-time phase increment for a given baud rate
package uart_baud_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int ACC_W_DEF      = 24;
  localparam int NUM_RATES      = 4;
  localparam int SEL_W          = $clog2(NUM_RATES);

  localparam int unsigned RATE_BAUD [NUM_RATES] = '{4800, 9600, 19200, 115200};

  // round(baud * os * 2^acc_w / clk_hz). Computed in 64 bits so the
  // intermediate product cannot overflow; the result fits in acc_w bits
  // for any rate below clk_hz / os.
  function automatic logic [63:0] calc_inc(input logic [63:0] baud,
                                           input logic [63:0] clk_hz,
                                           input int          os,
                                           input int          acc_w);
    logic [63:0] num;
    num = (baud * 64'(os)) << acc_w;
    return (num + (clk_hz >> 1)) / clk_hz;
  endfunction

endpackage

// File: rtl/uart_baud_nco.sv
// uart_baud_nco: fractional phase accumulator.
//   clk, rst - clock, synchronous active-high reset (clears acc)
//   en       - advance acc by inc this edge
//   clr      - clear acc this edge (wins over en)
//   inc      - phase increment
//   carry    - overflow of acc + inc; valid in the cycle before the edge
//              that commits it, so the caller can register it as a tick
module uart_baud_nco #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] inc,
  output logic             carry
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc};
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = sum[ACC_W-1:0];
  end

  assign carry = sum[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/uart_baud_gen_nco.sv
// uart_baud_gen_nco: NCO-based UART baud generator.
//   clk, rst   - clock, synchronous active-high reset
//   en         - run enable; when low everything holds and ticks are 0
//   baud_sel   - rate table index
//   use_custom - select custom_inc instead of the table
//   custom_inc - custom phase increment (0 = no ticks)
//   rx_resync  - start-bit edge pulse, restarts RX mid-bit phase
//   os_tick    - oversample tick
//   tx_tick    - TX bit-boundary tick (every OVERSAMPLE os ticks)
//   rx_sample  - RX mid-bit tick (OVERSAMPLE/2 os ticks after resync)
module uart_baud_gen_nco
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 200_000_000,
  parameter int          OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int          ACC_W       = ACC_W_DEF,
  parameter int          NUM_RATES   = uart_baud_pkg::NUM_RATES,
  parameter int          SEL_W       = $clog2(NUM_RATES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] baud_sel,
  input  logic             use_custom,
  input  logic [ACC_W-1:0] custom_inc,
  input  logic             rx_resync,
  output logic             os_tick,
  output logic             tx_tick,
  output logic             rx_sample
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [ACC_W-1:0] rate_inc [NUM_RATES];

  for (genvar gi = 0; gi < NUM_RATES; gi++) begin : g_rate
    localparam logic [ACC_W-1:0] INC =
      ACC_W'(calc_inc(64'(RATE_BAUD[gi]), 64'(CLK_FREQ_HZ), OVERSAMPLE, ACC_W));
    assign rate_inc[gi] = INC;
  end

  logic [ACC_W-1:0] inc_sel, inc_q, inc_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d, rx_cnt_q, rx_cnt_d;
  logic             os_tick_q, os_tick_d, tx_tick_q, tx_tick_d;
  logic             rx_sample_q, rx_sample_d;
  logic             cfg_chg, carry, tick;

  assign inc_sel = use_custom ? custom_inc : rate_inc[baud_sel];
  // A rate change restarts phase from zero so the new rate is clean.
  assign cfg_chg = en && (inc_sel != inc_q);

  uart_baud_nco #(.ACC_W(ACC_W)) u_nco (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (cfg_chg),
    .inc   (inc_q),
    .carry (carry)
  );

  assign tick = en && !cfg_chg && carry;

  always_comb begin
    inc_d       = inc_q;
    os_cnt_d    = os_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    os_tick_d   = 1'b0;
    tx_tick_d   = 1'b0;
    rx_sample_d = 1'b0;
    if (cfg_chg) begin
      inc_d    = inc_sel;
      os_cnt_d = '0;
      rx_cnt_d = '0;
    end else if (en) begin
      if (tick) begin
        os_tick_d = 1'b1;
        tx_tick_d = (os_cnt_q == OS_LAST);
        os_cnt_d  = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
      end
      // Resync beats a coincident carry: the RX phase restarts here.
      if (rx_resync) begin
        rx_cnt_d = '0;
      end else if (tick) begin
        rx_sample_d = (rx_cnt_q == OS_MID);
        rx_cnt_d    = (rx_cnt_q == OS_LAST) ? '0 : rx_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q       <= inc_sel;
      os_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      os_tick_q   <= 1'b0;
      tx_tick_q   <= 1'b0;
      rx_sample_q <= 1'b0;
    end else begin
      inc_q       <= inc_d;
      os_cnt_q    <= os_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      os_tick_q   <= os_tick_d;
      tx_tick_q   <= tx_tick_d;
      rx_sample_q <= rx_sample_d;
    end
  end

  assign os_tick   = os_tick_q;
  assign tx_tick   = tx_tick_q;
  assign rx_sample = rx_sample_q;

endmodule

// File: tb/tb_uart_baud_gen_nco.sv
// Bench for uart_baud_gen_nco: directed scenarios plus randomized traffic,
// every cycle compared against a phase/tick-count reference model.
module tb_uart_baud_gen_nco;

  localparam int ACC_W = 24;
  localparam int OS    = 16;
  localparam logic [ACC_W-1:0] TBL [4] = '{24'd6442, 24'd12885, 24'd25770, 24'd154619};

  logic             clk = 1'b0;
  logic             rst, en, use_custom, rx_resync;
  logic [1:0]       baud_sel;
  logic [ACC_W-1:0] custom_inc;
  logic             os_tick, tx_tick, rx_sample;

  always #5 clk = ~clk;

  uart_baud_gen_nco dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .baud_sel   (baud_sel),
    .use_custom (use_custom),
    .custom_inc (custom_inc),
    .rx_resync  (rx_resync),
    .os_tick    (os_tick),
    .tx_tick    (tx_tick),
    .rx_sample  (rx_sample)
  );

  int checks = 0, errors = 0, ecnt = -1;

  // Reference: total phase since last clear, os ticks since clear,
  // os ticks since last RX resync/clear.
  longint           m_phase;
  int               m_os, m_rx;
  logic [ACC_W-1:0] m_inc;
  logic             e_os, e_tx, e_rx;

  int first_os, first_tx, first_rx, n_os, n_tx, n_rx, last_os, min_iv, max_iv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mark();
    first_os = -1; first_tx = -1; first_rx = -1;
    n_os = 0; n_tx = 0; n_rx = 0;
    last_os = -1; min_iv = 1 << 30; max_iv = 0;
  endtask

  task automatic model();
    logic [ACC_W-1:0] sel;
    longint np;
    sel  = use_custom ? custom_inc : TBL[baud_sel];
    e_os = 1'b0; e_tx = 1'b0; e_rx = 1'b0;
    if (rst) begin
      m_phase = 0; m_os = 0; m_rx = 0; m_inc = sel;
    end else if (!en) begin
      // hold
    end else if (sel != m_inc) begin
      m_phase = 0; m_os = 0; m_rx = 0; m_inc = sel;
    end else begin
      np      = m_phase + longint'(m_inc);
      e_os    = (np >> ACC_W) != (m_phase >> ACC_W);
      m_phase = np;
      if (e_os) begin
        m_os++;
        e_tx = (m_os % OS) == 0;
      end
      if (rx_resync) m_rx = 0;
      else if (e_os) begin
        m_rx++;
        e_rx = (m_rx % OS) == OS / 2;
      end
    end
  endtask

  task automatic step();
    int iv;
    model();
    @(posedge clk);
    ecnt++;
    @(negedge clk);
    chk("os_tick", os_tick, e_os);
    chk("tx_tick", tx_tick, e_tx);
    chk("rx_sample", rx_sample, e_rx);
    if (os_tick === 1'b1) begin
      n_os++;
      if (first_os < 0) first_os = ecnt;
      if (last_os >= 0) begin
        iv = ecnt - last_os;
        if (iv < min_iv) min_iv = iv;
        if (iv > max_iv) max_iv = iv;
      end
      last_os = ecnt;
    end
    if (tx_tick === 1'b1) begin
      n_tx++;
      if (first_tx < 0) first_tx = ecnt;
    end
    if (rx_sample === 1'b1) begin
      n_rx++;
      if (first_rx < 0) first_rx = ecnt;
    end
  endtask

  task automatic run_to(input int n);
    while (ecnt < n) step();
  endtask

  initial begin
    longint exp_n;
    int r;
    rst = 1'b1; en = 1'b1; use_custom = 1'b1; custom_inc = 24'h100000;
    baud_sel = 2'd0; rx_resync = 1'b0;
    mark();

    // Reset at edge 0, then free-run at 2^20.
    step();
    chk("rst_os", os_tick, 1'b0);
    chk("rst_tx", tx_tick, 1'b0);
    chk("rst_rx", rx_sample, 1'b0);
    rst = 1'b0;
    mark();
    run_to(300);
    chk("first_os", first_os, 16);
    chk("first_tx", first_tx, 256);
    chk("first_rx", first_rx, 128);
    chk("n_os_300", n_os, 18);

    // RX resync off a carry edge; TX phase must not move.
    run_to(999);
    rx_resync = 1'b1; step(); rx_resync = 1'b0;
    mark();
    run_to(1400);
    chk("resync_first_rx", first_rx, 1120);
    chk("resync_first_tx", first_tx, 1024);
    chk("resync_n_rx", n_rx, 2);

    // Resync on an edge that carries and would have sampled.
    run_to(1631);
    rx_resync = 1'b1; step(); rx_resync = 1'b0;
    chk("coinc_os", os_tick, 1'b1);
    chk("coinc_rx", rx_sample, 1'b0);
    mark();
    run_to(1900);
    chk("coinc_next_rx", first_rx, 1760);

    // Rate change on a carry edge: tick suppressed, restart at new rate.
    run_to(1999);
    custom_inc = 24'h200000; step();
    chk("chg_os", os_tick, 1'b0);
    chk("chg_tx", tx_tick, 1'b0);
    mark();
    run_to(2200);
    chk("chg_first_os", first_os, 2008);
    chk("chg_first_tx", first_tx, 2128);
    chk("chg_first_rx", first_rx, 2064);

    // Pause mid-period; phase resumes from held accumulator.
    run_to(2202);
    en = 1'b0;
    mark();
    repeat (100) step();
    chk("pause_n_os", n_os, 0);
    chk("pause_n_tx", n_tx, 0);
    chk("pause_n_rx", n_rx, 0);
    en = 1'b1;
    mark();
    run_to(2320);
    chk("resume_first_os", first_os, 2308);

    // Reset mid-run with a new custom rate.
    run_to(2399);
    custom_inc = 24'h100000; rst = 1'b1; step(); rst = 1'b0;
    mark();
    run_to(2500);
    chk("rerst_first_os", first_os, 2416);
    chk("rerst_n_os", n_os, 6);

    // Table rate 19200.
    run_to(2599);
    use_custom = 1'b0; baud_sel = 2'd2; step();
    mark();
    run_to(2600 + 40000);
    exp_n = (longint'(40000) * 25770) >> ACC_W;
    chk("t2_n_os", n_os, exp_n);
    chk("t2_n_tx", n_tx, exp_n / 16);
    chk("t2_min_iv", min_iv, 651);
    chk("t2_max_iv", max_iv, 652);

    // Table rate 115200.
    baud_sel = 2'd3; step();
    mark();
    repeat (3000) step();
    exp_n = (longint'(3000) * 154619) >> ACC_W;
    chk("t3_n_os", n_os, exp_n);
    chk("t3_min_iv", min_iv, 108);
    chk("t3_max_iv", max_iv, 109);

    // Table rate 4800.
    baud_sel = 2'd0; step();
    mark();
    repeat (10000) step();
    exp_n = (longint'(10000) * 6442) >> ACC_W;
    chk("t0_n_os", n_os, exp_n);

    // Randomized traffic against the model.
    for (int i = 0; i < 20000; i++) begin
      r         = int'($urandom_range(0, 999));
      rst       = (r < 2);
      en        = ($urandom_range(0, 9) != 0);
      rx_resync = ($urandom_range(0, 19) == 0);
      if (r >= 990) begin
        use_custom = 1'($urandom_range(0, 1));
        baud_sel   = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       custom_inc = '0;
          1:       custom_inc = 24'($urandom_range(1, 4096)) << 8;
          2:       custom_inc = 24'($urandom);
          default: custom_inc = 24'h800000 | 24'($urandom);
        endcase
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
